// File: rtl/mpc_pkg.sv
// Shared types and sizing for the MPC cache-line decompressor.
// Build option: DECOMP_INPUT_REG_EN adds an input register stage.
package mpc_pkg;

    localparam int NUM_PATTERNS = 8;
    localparam int LEN_ENCODE   = $clog2(NUM_PATTERNS);
    localparam int LINE_W       = 256;
    localparam int WORD_W       = 32;
    localparam int NUM_WORDS    = LINE_W / WORD_W;
    localparam int IN_W         = LINE_W + LEN_ENCODE;

    typedef enum logic [LEN_ENCODE-1:0] {
        PAT_ZERO     = 3'd0,
        PAT_REP8     = 3'd1,
        PAT_REP32    = 3'd2,
        PAT_REP64    = 3'd3,
        PAT_BDI      = 3'd4,
        PAT_NARROW_U = 3'd5,
        PAT_NARROW_S = 3'd6,
        PAT_RAW      = 3'd7
    } pattern_e;

endpackage

// File: rtl/mpc_pattern_expand.sv
// Combinational expansion of one compressed payload into a full line.
// Build option: none (DECOMP_INPUT_REG_EN only affects the top).
module mpc_pattern_expand
    import mpc_pkg::*;
(
    input  logic [LEN_ENCODE-1:0] encode,
    input  logic [LINE_W-1:0]     payload,
    output logic [LINE_W-1:0]     line
);

    pattern_e          pat;
    logic [WORD_W-1:0] base;
    logic [LINE_W-1:0] bdi_line;
    logic [LINE_W-1:0] nu_line;
    logic [LINE_W-1:0] ns_line;

    assign pat  = pattern_e'(encode);
    assign base = payload[WORD_W-1:0];

    // Per-word lanes; carries out of each 32-bit add are dropped.
    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_word
        logic [7:0]  delta;
        logic [15:0] half;

        assign delta = payload[WORD_W+8*g +: 8];
        assign half  = payload[16*g +: 16];

        assign bdi_line[WORD_W*g +: WORD_W] =
            base + {{24{delta[7]}}, delta};
        assign nu_line[WORD_W*g +: WORD_W] =
            {16'h0000, half};
        assign ns_line[WORD_W*g +: WORD_W] =
            {{16{half[15]}}, half};
    end

    always_comb begin
        line = '0;
        unique case (pat)
            PAT_ZERO:     line = '0;
            PAT_REP8:     line = {(LINE_W/8){payload[7:0]}};
            PAT_REP32:    line = {(LINE_W/32){payload[31:0]}};
            PAT_REP64:    line = {(LINE_W/64){payload[63:0]}};
            PAT_BDI:      line = bdi_line;
            PAT_NARROW_U: line = nu_line;
            PAT_NARROW_S: line = ns_line;
            PAT_RAW:      line = payload;
        endcase
    end

endmodule

// File: rtl/mpc_decompressor.sv
// Registered cache-line decompressor: decode + output register.
// Build option: DECOMP_INPUT_REG_EN adds an input stage (2-cycle latency).
module mpc_decompressor
    import mpc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IN_W-1:0]   data_i,
    input  logic              en_i,
    output logic [LINE_W-1:0] data_o,
    output logic              en_o
);

    logic [IN_W-1:0]   data_s;
    logic              en_s;
    logic [LINE_W-1:0] line;

`ifdef DECOMP_INPUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_s <= '0;
            en_s   <= 1'b0;
        end else begin
            data_s <= data_i;
            en_s   <= en_i;
        end
    end
`else
    assign data_s = data_i;
    assign en_s   = en_i;
`endif

    mpc_pattern_expand u_expand (
        .encode  (data_s[LINE_W +: LEN_ENCODE]),
        .payload (data_s[LINE_W-1:0]),
        .line    (line)
    );

    // Line holds while idle so downstream can sample it late.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o <= '0;
            en_o   <= 1'b0;
        end else begin
            en_o <= en_s;
            if (en_s) begin
                data_o <= line;
            end
        end
    end

endmodule

// File: tb/tb_mpc_decompressor.sv
// Directed self-checking bench for mpc_decompressor.
// Honours DECOMP_INPUT_REG_EN for the expected latency.
module tb_mpc_decompressor;
    import mpc_pkg::*;

`ifdef DECOMP_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int N_STREAM = 10000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [258:0] data_i;
    logic         en_i;
    logic [255:0] data_o;
    logic         en_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mpc_decompressor dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_i (data_i),
        .en_i   (en_i),
        .data_o (data_o),
        .en_o   (en_o)
    );

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Reference decoder, written word by word with signed arithmetic.
    function automatic logic [255:0] golden(input logic [2:0] e,
                                            input logic [255:0] p);
        logic [255:0]       r;
        logic [31:0]        v;
        logic signed [31:0] sx;
        r = '0;
        for (int w = 0; w < 8; w++) begin
            case (e)
                3'd0: v = 32'h0;
                3'd1: v = {p[7:0], p[7:0], p[7:0], p[7:0]};
                3'd2: v = p[31:0];
                3'd3: v = (w % 2 == 0) ? p[31:0] : p[63:32];
                3'd4: begin
                    sx = $signed(p[32+8*w +: 8]);
                    v  = p[31:0] + sx;
                end
                3'd5: v = 32'(p[16*w +: 16]);
                3'd6: begin
                    sx = $signed(p[16*w +: 16]);
                    v  = sx;
                end
                default: v = p[32*w +: 32];
            endcase
            r[32*w +: 32] = v;
        end
        return r;
    endfunction

    // Presents one line for a single cycle and waits until it is out.
    task automatic drive_line(input logic [2:0] e, input logic [255:0] p);
        data_i = {e, p};
        en_i   = 1'b1;
        @(posedge clk); #1;
        en_i = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n  = 1'b0;
        en_i   = 1'b1;
        data_i = {3'd7, {256{1'b1}}};
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (data_o !== 256'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", data_o);
        end
        total++;
        if (en_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_en: got %b want 0", en_o);
        end
        rst_n = 1'b1;
        cyc   = 0;
        while (en_o !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc !== LAT) begin
            bad++;
            $display("FAIL reset_latency: got %0d want %0d", cyc, LAT);
        end
        total++;
        if (data_o !== {256{1'b1}}) begin
            bad++;
            $display("FAIL reset_first_data: got %h want all ones", data_o);
        end
        en_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_repeats();
        logic [255:0] p;
        p = rand256();
        p[7:0] = 8'hA5;
        drive_line(3'd1, p);
        total++;
        if (data_o !== {32{8'hA5}}) begin
            bad++;
            $display("FAIL rep8: got %h want %h", data_o, {32{8'hA5}});
        end
        total++;
        if (en_o !== 1'b1) begin
            bad++;
            $display("FAIL rep8_en: got %b want 1", en_o);
        end
        p = rand256();
        p[31:0] = 32'hDEADBEEF;
        drive_line(3'd2, p);
        total++;
        if (data_o !== {8{32'hDEADBEEF}}) begin
            bad++;
            $display("FAIL rep32: got %h want %h", data_o, {8{32'hDEADBEEF}});
        end
        p = rand256();
        p[63:0] = 64'h0123456789ABCDEF;
        drive_line(3'd3, p);
        total++;
        if (data_o !== {4{64'h0123456789ABCDEF}}) begin
            bad++;
            $display("FAIL rep64: got %h want %h", data_o,
                     {4{64'h0123456789ABCDEF}});
        end
    endtask

    task automatic test_bdi();
        logic [255:0] p;
        logic [255:0] want;
        p = rand256();
        p[95:0] = {32'h00FF0201, 32'h00000000, 32'hFFFFFFFE};
        p[95:64] = 32'h0;
        p[63:32] = 32'h00FF0201;
        want = {{5{32'hFFFFFFFE}}, 32'hFFFFFFFD, 32'h00000000, 32'hFFFFFFFF};
        drive_line(3'd4, p);
        total++;
        if (data_o[31:0] !== 32'hFFFFFFFF) begin
            bad++;
            $display("FAIL bdi_w0: got %h want ffffffff", data_o[31:0]);
        end
        total++;
        if (data_o[63:32] !== 32'h00000000) begin
            bad++;
            $display("FAIL bdi_w1_wrap: got %h want 00000000", data_o[63:32]);
        end
        total++;
        if (data_o[95:64] !== 32'hFFFFFFFD) begin
            bad++;
            $display("FAIL bdi_w2: got %h want fffffffd", data_o[95:64]);
        end
        total++;
        if (data_o !== want) begin
            bad++;
            $display("FAIL bdi_line: got %h want %h", data_o, want);
        end
    endtask

    task automatic test_narrow();
        logic [255:0] p;
        p = rand256();
        p[31:0] = 32'h7FFF8001;
        drive_line(3'd5, p);
        total++;
        if (data_o[31:0] !== 32'h00008001) begin
            bad++;
            $display("FAIL narrow_u_w0: got %h want 00008001", data_o[31:0]);
        end
        total++;
        if (data_o[63:32] !== 32'h00007FFF) begin
            bad++;
            $display("FAIL narrow_u_w1: got %h want 00007fff", data_o[63:32]);
        end
        drive_line(3'd6, p);
        total++;
        if (data_o[31:0] !== 32'hFFFF8001) begin
            bad++;
            $display("FAIL narrow_s_w0: got %h want ffff8001", data_o[31:0]);
        end
        total++;
        if (data_o[63:32] !== 32'h00007FFF) begin
            bad++;
            $display("FAIL narrow_s_w1: got %h want 00007fff", data_o[63:32]);
        end
    endtask

    task automatic test_zero_raw();
        logic [255:0] p;
        drive_line(3'd0, {256{1'b1}});
        total++;
        if (data_o !== 256'h0) begin
            bad++;
            $display("FAIL zero: got %h want 0", data_o);
        end
        p = rand256();
        drive_line(3'd7, p);
        total++;
        if (data_o !== p) begin
            bad++;
            $display("FAIL raw: got %h want %h", data_o, p);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] expq[$];
        logic [255:0] p;
        logic [255:0] want;
        logic [255:0] first_got;
        logic [255:0] first_want;
        logic [2:0]   e;
        int           errs;
        int           first;
        errs  = 0;
        first = -1;
        first_got  = '0;
        first_want = '0;
        for (int i = 0; i < N_STREAM + LAT - 1; i++) begin
            if (i < N_STREAM) begin
                e = 3'($urandom_range(0, 7));
                p = rand256();
                data_i = {e, p};
                en_i   = 1'b1;
                expq.push_back(golden(e, p));
            end else begin
                en_i = 1'b0;
            end
            @(posedge clk); #1;
            if (i >= LAT - 1) begin
                want = expq.pop_front();
                if (data_o !== want || en_o !== 1'b1) begin
                    errs++;
                    if (first < 0) begin
                        first      = i - (LAT - 1);
                        first_got  = data_o;
                        first_want = want;
                    end
                end
            end
        end
        en_i = 1'b0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL b2b: %0d bad items, first #%0d got %h want %h",
                     errs, first, first_got, first_want);
        end
    endtask

    task automatic test_hold();
        bit           ens[6];
        logic [255:0] pl[6];
        logic [255:0] held;
        int           j;
        ens  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        held = '0;
        for (int k = 0; k < 6; k++) pl[k] = rand256();
        for (int k = 0; k < 6 + LAT - 1; k++) begin
            if (k < 6) begin
                en_i   = ens[k];
                data_i = {3'd7, pl[k]};
            end else begin
                en_i = 1'b0;
            end
            @(posedge clk); #1;
            if (k >= LAT - 1) begin
                j = k - (LAT - 1);
                if (ens[j]) held = pl[j];
                total++;
                if (en_o !== ens[j]) begin
                    bad++;
                    $display("FAIL hold_en[%0d]: got %b want %b",
                             j, en_o, ens[j]);
                end
                total++;
                if (data_o !== held) begin
                    bad++;
                    $display("FAIL hold_data[%0d]: got %h want %h",
                             j, data_o, held);
                end
            end
        end
        en_i = 1'b0;
    endtask

    task automatic test_reset_midstream();
        logic [255:0] p;
        int           cyc;
        p = rand256();
        drive_line(3'd7, p);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (data_o !== 256'h0 || en_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_clear: got %h/%b want 0/0", data_o, en_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (en_o !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: got %b want 0", en_o);
        end
        p = rand256();
        data_i = {3'd2, p};
        en_i   = 1'b1;
        cyc    = 0;
        while (en_o !== 1'b1 && cyc < 8) begin
            @(posedge clk); #1;
            cyc++;
        end
        en_i = 1'b0;
        total++;
        if (cyc !== LAT) begin
            bad++;
            $display("FAIL midreset_latency: got %0d want %0d", cyc, LAT);
        end
        total++;
        if (data_o !== {8{p[31:0]}}) begin
            bad++;
            $display("FAIL midreset_data: got %h want %h",
                     data_o, {8{p[31:0]}});
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en_i   = 1'b0;
        data_i = '0;
        test_reset();
        test_repeats();
        test_bdi();
        test_narrow();
        test_zero_raw();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
